// File: rtl/scpad_types_pkg.sv
// scpad_types_pkg: shared widths, mask/struct types and FSM state for the scratchpad tile address generator.
// Widths and mask types below describe the default 32-bank, 16384-slot, 2-scratchpad build;
// parameterised modules derive their own widths the same way.
package scpad_types_pkg;
    localparam int NUM_COLS_DEF      = 32;
    localparam int NUM_ROWS_DEF      = 16384;
    localparam int MAX_TILE_SIZE_DEF = 32;
    localparam int NUM_SCPADS_DEF    = 2;
    localparam int ROW_IDX_WIDTH     = $clog2(NUM_ROWS_DEF);
    localparam int COL_IDX_WIDTH     = $clog2(NUM_COLS_DEF);
    localparam int MAX_DIM_WIDTH     = $clog2(MAX_TILE_SIZE_DEF);
    // One extra bit so out-of-range scratchpad ids can be presented and rejected.
    localparam int SCPAD_ID_WIDTH    = $clog2(NUM_SCPADS_DEF) + 1;
    typedef logic [NUM_COLS_DEF-1:0][ROW_IDX_WIDTH-1:0] slot_mask_t;
    typedef logic [NUM_COLS_DEF-1:0][COL_IDX_WIDTH-1:0] shift_mask_t;
    typedef logic [NUM_COLS_DEF-1:0]                    enable_mask_t;
    typedef struct packed {
        logic [ROW_IDX_WIDTH-1:0]  base_row;
        logic [MAX_DIM_WIDTH:0]    rows;
        logic [MAX_DIM_WIDTH:0]    cols;
        logic                      col_mode;
        logic [SCPAD_ID_WIDTH-1:0] scpad_id;
    } tile_req_t;
    typedef struct packed {
        slot_mask_t                slot_mask;
        shift_mask_t               shift_mask;
        enable_mask_t              enable_mask;
        logic [MAX_DIM_WIDTH-1:0]  idx;
        logic                      last;
        logic [SCPAD_ID_WIDTH-1:0] id;
    } tile_beat_t;
    typedef enum logic [1:0] {IDLE, RUN, ERR} addr_gen_state_t;
endpackage

// File: rtl/scpad_tile_addr_gen_if.sv
// scpad_tile_addr_gen_if: request and beat channels of the tile address generator.
// master = client (drives requests, consumes beats); slave = generator.
interface scpad_tile_addr_gen_if #(
    parameter int NUM_COLS      = 32,
    parameter int NUM_ROWS      = 16384,
    parameter int MAX_TILE_SIZE = 32,
    parameter int NUM_SCPADS    = 2
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int DW = $clog2(MAX_TILE_SIZE);
    localparam int IW = $clog2(NUM_SCPADS) + 1;
    logic                         req_valid;
    logic                         req_ready;
    logic [RW-1:0]                req_base_row;
    logic [DW:0]                  req_rows;
    logic [DW:0]                  req_cols;
    logic                         req_col_mode;
    logic [IW-1:0]                req_scpad_id;
    logic                         beat_valid;
    logic                         beat_ready;
    logic [NUM_COLS-1:0][RW-1:0]  beat_slot_mask;
    logic [NUM_COLS-1:0][CW-1:0]  beat_shift_mask;
    logic [NUM_COLS-1:0]          beat_enable_mask;
    logic [DW-1:0]                beat_idx;
    logic                         beat_last;
    logic [IW-1:0]                beat_scpad_id;
    logic                         err_pulse;
    modport master (
        output req_valid, req_base_row, req_rows, req_cols, req_col_mode, req_scpad_id, beat_ready,
        input  req_ready, beat_valid, beat_slot_mask, beat_shift_mask, beat_enable_mask,
               beat_idx, beat_last, beat_scpad_id, err_pulse
    );
    modport slave (
        input  req_valid, req_base_row, req_rows, req_cols, req_col_mode, req_scpad_id, beat_ready,
        output req_ready, beat_valid, beat_slot_mask, beat_shift_mask, beat_enable_mask,
               beat_idx, beat_last, beat_scpad_id, err_pulse
    );
endinterface

// File: rtl/scpad_lane_map.sv
// scpad_lane_map: combinational per-bank slot/shift/enable mapping for one beat.
// Ports: idx_i beat number, col_mode_i orientation, rows_i/cols_i tile dims, base_i first slot;
//        slot_o/shift_o/en_o per-bank masks (disabled lanes read 0).
module scpad_lane_map #(
    parameter int NUM_COLS      = 32,
    parameter int NUM_ROWS      = 16384,
    parameter int MAX_TILE_SIZE = 32,
    parameter int SWIZZLE_EN    = 1,
    localparam int RW = $clog2(NUM_ROWS),
    localparam int CW = $clog2(NUM_COLS),
    localparam int DW = $clog2(MAX_TILE_SIZE)
) (
    input  logic [DW-1:0]                idx_i,
    input  logic                         col_mode_i,
    input  logic [DW:0]                  rows_i,
    input  logic [DW:0]                  cols_i,
    input  logic [RW-1:0]                base_i,
    output logic [NUM_COLS-1:0][RW-1:0]  slot_o,
    output logic [NUM_COLS-1:0][CW-1:0]  shift_o,
    output logic [NUM_COLS-1:0]          en_o
);
    for (genvar l = 0; l < NUM_COLS; l++) begin : g_lane
        // d is the tile coordinate held by bank l: column in row mode, row in column mode.
        // Swizzle places (r,c) at bank c+r, so undoing it is a subtract modulo NUM_COLS.
        logic [CW-1:0] d;
        assign d          = (col_mode_i || SWIZZLE_EN != 0) ? CW'(l) - CW'(idx_i) : CW'(l);
        assign en_o[l]    = 32'(d) < 32'(col_mode_i ? rows_i : cols_i);
        assign slot_o[l]  = en_o[l] ? base_i + RW'(col_mode_i ? d : CW'(idx_i)) : '0;
        assign shift_o[l] = en_o[l] ? d : '0;
    end
endmodule

// File: rtl/scpad_tile_addr_gen.sv
// scpad_tile_addr_gen: turns one tile request into a sequence of per-bank SRAM access beats.
// Ports: clk, rst (async active-high); bus_if (slave) carries the request channel,
//        the registered beat channel and err_pulse for rejected requests.
module scpad_tile_addr_gen import scpad_types_pkg::*; #(
    parameter int NUM_COLS      = NUM_COLS_DEF,
    parameter int NUM_ROWS      = NUM_ROWS_DEF,
    parameter int MAX_TILE_SIZE = MAX_TILE_SIZE_DEF,
    parameter int NUM_SCPADS    = NUM_SCPADS_DEF,
    parameter int SWIZZLE_EN    = 1,
    localparam int RW = $clog2(NUM_ROWS),
    localparam int CW = $clog2(NUM_COLS),
    localparam int DW = $clog2(MAX_TILE_SIZE),
    localparam int IW = $clog2(NUM_SCPADS) + 1
) (
    input logic                  clk,
    input logic                  rst,
    scpad_tile_addr_gen_if.slave bus_if
);
    addr_gen_state_t state_q, state_d;
    logic [RW-1:0] base_q, m_base;
    logic [DW:0] rows_q, cols_q, m_rows, m_cols, count_m1;
    logic mode_q, m_mode, last_q, st_idle, legal, accept, hs, load;
    logic [IW-1:0] id_q;
    logic [DW-1:0] idx_q, idx_n;
    logic [NUM_COLS-1:0][RW-1:0] slot_q, slot_n;
    logic [NUM_COLS-1:0][CW-1:0] shift_q, shift_n;
    logic [NUM_COLS-1:0] en_q, en_n;
    assign st_idle = state_q == IDLE;
    assign legal   = bus_if.req_rows != '0 && bus_if.req_cols != '0
                  && bus_if.req_rows <= (DW+1)'(MAX_TILE_SIZE) && bus_if.req_cols <= (DW+1)'(MAX_TILE_SIZE)
                  && bus_if.req_scpad_id < IW'(NUM_SCPADS) && !(bus_if.req_col_mode && SWIZZLE_EN == 0);
    assign accept  = st_idle && bus_if.req_valid;
    assign hs      = state_q == RUN && bus_if.beat_ready;
    // In IDLE the first beat is mapped straight from the request; afterwards from the latched copy.
    assign m_base   = st_idle ? bus_if.req_base_row : base_q;
    assign m_rows   = st_idle ? bus_if.req_rows : rows_q;
    assign m_cols   = st_idle ? bus_if.req_cols : cols_q;
    assign m_mode   = st_idle ? bus_if.req_col_mode : mode_q;
    assign idx_n    = st_idle ? '0 : idx_q + DW'(1);
    assign count_m1 = (m_mode ? m_cols : m_rows) - (DW+1)'(1);
    assign load     = (accept && legal) || (hs && !last_q);
    scpad_lane_map #(
        .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS), .MAX_TILE_SIZE(MAX_TILE_SIZE), .SWIZZLE_EN(SWIZZLE_EN)
    ) u_map (
        .idx_i(idx_n), .col_mode_i(m_mode), .rows_i(m_rows), .cols_i(m_cols), .base_i(m_base),
        .slot_o(slot_n), .shift_o(shift_n), .en_o(en_n)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (accept ? (legal ? RUN : ERR) : IDLE)
                : state_q == ERR  ? IDLE
                : (hs && last_q)  ? IDLE : RUN;
    end
    always_comb begin
        bus_if.req_ready  = state_q == IDLE;
        bus_if.beat_valid = state_q == RUN;
        bus_if.err_pulse  = state_q == ERR;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {base_q, rows_q, cols_q, mode_q, id_q} <= '0;
            {idx_q, last_q, slot_q, shift_q, en_q} <= '0;
        end else begin
            if (accept) {base_q, rows_q, cols_q, mode_q, id_q} <= {bus_if.req_base_row, bus_if.req_rows,
                bus_if.req_cols, bus_if.req_col_mode, bus_if.req_scpad_id};
            if (load) begin
                idx_q   <= idx_n;
                last_q  <= {1'b0, idx_n} == count_m1;
                slot_q  <= slot_n;
                shift_q <= shift_n;
                en_q    <= en_n;
            end
        end
    end
    assign bus_if.beat_slot_mask   = slot_q;
    assign bus_if.beat_shift_mask  = shift_q;
    assign bus_if.beat_enable_mask = en_q;
    assign bus_if.beat_idx         = idx_q;
    assign bus_if.beat_last        = last_q;
    assign bus_if.beat_scpad_id    = id_q;
endmodule

// File: tb/tb_scpad_tile_addr_gen.sv
// tb_scpad_tile_addr_gen: directed scenarios for the tile address generator (swizzled and linear builds).
module tb_scpad_tile_addr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    scpad_tile_addr_gen_if if0 ();
    scpad_tile_addr_gen_if if1 ();
    scpad_tile_addr_gen #(.SWIZZLE_EN(1)) dut0 (.clk(clk), .rst(rst), .bus_if(if0.slave));
    scpad_tile_addr_gen #(.SWIZZLE_EN(0)) dut1 (.clk(clk), .rst(rst), .bus_if(if1.slave));
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic req0(input logic [13:0] b, input logic [5:0] r, input logic [5:0] c, input logic m, input logic [1:0] id);
        if0.req_valid = 1'b1; if0.req_base_row = b; if0.req_rows = r; if0.req_cols = c;
        if0.req_col_mode = m; if0.req_scpad_id = id;
        step;
        if0.req_valid = 1'b0;
    endtask
    task automatic test_reset;
        checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", if0.req_ready); end
        checks++; if (if0.beat_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if0.beat_valid); end
        checks++; if (if0.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", if0.err_pulse); end
        checks++; if (if0.beat_enable_mask !== '0) begin errors++; $display("FAIL reset_en got=%h exp=0", if0.beat_enable_mask); end
        checks++; if (if0.beat_slot_mask !== '0 || if0.beat_shift_mask !== '0) begin errors++; $display("FAIL reset_masks nonzero exp=0"); end
        checks++; if ({if0.beat_idx, if0.beat_last, if0.beat_scpad_id} !== '0) begin errors++;
            $display("FAIL reset_idx got=%0d/%b/%0d exp=0", if0.beat_idx, if0.beat_last, if0.beat_scpad_id); end
    endtask
    task automatic test_row_mode;
        int n = 0;
        req0(14'd100, 6'd4, 6'd32, 1'b0, 2'd0);
        checks++; if (if0.beat_valid !== 1'b1) begin errors++; $display("FAIL row_latency got=%b exp=1", if0.beat_valid); end
        while (if0.beat_valid && n < 40) begin
            checks++; if (if0.beat_idx !== 5'(n) || if0.beat_last !== (n == 3)) begin errors++;
                $display("FAIL row_idx got=%0d last=%b exp=%0d last=%b", if0.beat_idx, if0.beat_last, n, n == 3); end
            if (n == 1) begin
                checks++; if (if0.beat_slot_mask[0] !== 14'd101 || if0.beat_slot_mask[31] !== 14'd101) begin errors++;
                    $display("FAIL row_slot got=%0d exp=101", if0.beat_slot_mask[0]); end
                checks++; if (if0.beat_shift_mask[0] !== 5'd31) begin errors++; $display("FAIL row_shift0 got=%0d exp=31", if0.beat_shift_mask[0]); end
                checks++; if (if0.beat_shift_mask[5] !== 5'd4) begin errors++; $display("FAIL row_shift5 got=%0d exp=4", if0.beat_shift_mask[5]); end
                checks++; if (if0.beat_enable_mask !== 32'hFFFF_FFFF) begin errors++; $display("FAIL row_en got=%h exp=ffffffff", if0.beat_enable_mask); end
            end
            n++;
            step;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL row_count got=%0d exp=4", n); end
        checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL row_ready_after got=%b exp=1", if0.req_ready); end
    endtask
    task automatic test_col_mode;
        int n = 0;
        req0(14'd0, 6'd8, 6'd3, 1'b1, 2'd1);
        while (if0.beat_valid && n < 40) begin
            checks++; if (if0.beat_scpad_id !== 2'd1) begin errors++; $display("FAIL col_id got=%0d exp=1", if0.beat_scpad_id); end
            if (n == 2) begin
                checks++; if (if0.beat_slot_mask[2] !== 14'd0 || if0.beat_shift_mask[2] !== 5'd0) begin errors++;
                    $display("FAIL col_bank2 got=%0d/%0d exp=0/0", if0.beat_slot_mask[2], if0.beat_shift_mask[2]); end
                checks++; if (if0.beat_slot_mask[9] !== 14'd7 || if0.beat_shift_mask[9] !== 5'd7) begin errors++;
                    $display("FAIL col_bank9 got=%0d/%0d exp=7/7", if0.beat_slot_mask[9], if0.beat_shift_mask[9]); end
                checks++; if (if0.beat_enable_mask !== 32'h0000_03FC) begin errors++; $display("FAIL col_en got=%h exp=000003fc", if0.beat_enable_mask); end
                checks++; if (if0.beat_slot_mask[10] !== 14'd0 || if0.beat_shift_mask[10] !== 5'd0 || if0.beat_shift_mask[1] !== 5'd0) begin errors++;
                    $display("FAIL col_disabled got=%0d/%0d exp=0/0", if0.beat_slot_mask[10], if0.beat_shift_mask[10]); end
                checks++; if (if0.beat_last !== 1'b1) begin errors++; $display("FAIL col_last got=%b exp=1", if0.beat_last); end
            end
            n++;
            step;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL col_count got=%0d exp=3", n); end
    endtask
    task automatic test_wrap;
        logic [13:0] exp_slot [4] = '{14'd16382, 14'd16383, 14'd0, 14'd1};
        int n = 0;
        req0(14'd16382, 6'd4, 6'd32, 1'b0, 2'd0);
        while (if0.beat_valid && n < 4) begin
            checks++; if (if0.beat_slot_mask[7] !== exp_slot[n]) begin errors++;
                $display("FAIL wrap_slot beat=%0d got=%0d exp=%0d", n, if0.beat_slot_mask[7], exp_slot[n]); end
            n++;
            step;
        end
        checks++; if (n != 4 || if0.beat_valid !== 1'b0) begin errors++; $display("FAIL wrap_count got=%0d exp=4", n); end
    endtask
    task automatic test_backpressure;
        if0.beat_ready = 1'b0;
        req0(14'd50, 6'd2, 6'd4, 1'b0, 2'd1);
        if0.req_valid = 1'b1; if0.req_base_row = 14'd999; if0.req_rows = 6'd9; if0.req_col_mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (if0.beat_valid !== 1'b1 || if0.beat_idx !== 5'd0 || if0.req_ready !== 1'b0) begin errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b idx=%0d rdy=%b exp v=1 idx=0 rdy=0", k, if0.beat_valid, if0.beat_idx, if0.req_ready); end
            checks++; if (if0.beat_enable_mask !== 32'h0000_000F || if0.beat_slot_mask[3] !== 14'd50 || if0.beat_shift_mask[3] !== 5'd3) begin errors++;
                $display("FAIL bp_masks cyc=%0d got en=%h slot=%0d exp en=f slot=50", k, if0.beat_enable_mask, if0.beat_slot_mask[3]); end
            step;
        end
        if0.req_valid = 1'b0;
        if0.beat_ready = 1'b1;
        step;
        checks++; if (if0.beat_idx !== 5'd1 || if0.beat_enable_mask !== 32'h0000_001E || if0.beat_slot_mask[1] !== 14'd51 || if0.beat_last !== 1'b1) begin errors++;
            $display("FAIL bp_beat1 got idx=%0d en=%h slot=%0d exp idx=1 en=1e slot=51", if0.beat_idx, if0.beat_enable_mask, if0.beat_slot_mask[1]); end
        step;
        checks++; if (if0.beat_valid !== 1'b0 || if0.req_ready !== 1'b1) begin errors++; $display("FAIL bp_end got v=%b exp=0", if0.beat_valid); end
    endtask
    task automatic test_illegal(input logic [5:0] r, input logic [5:0] c, input logic [1:0] id, input string nm);
        req0(14'd5, r, c, 1'b0, id);
        checks++; if (if0.err_pulse !== 1'b1 || if0.beat_valid !== 1'b0 || if0.req_ready !== 1'b0) begin errors++;
            $display("FAIL %s_err got e=%b v=%b rdy=%b exp e=1 v=0 rdy=0", nm, if0.err_pulse, if0.beat_valid, if0.req_ready); end
        step;
        checks++; if (if0.err_pulse !== 1'b0 || if0.beat_valid !== 1'b0 || if0.req_ready !== 1'b1) begin errors++;
            $display("FAIL %s_recover got e=%b v=%b rdy=%b exp e=0 v=0 rdy=1", nm, if0.err_pulse, if0.beat_valid, if0.req_ready); end
    endtask
    task automatic test_linear;
        if1.req_valid = 1'b1; if1.req_base_row = 14'd0; if1.req_rows = 6'd4; if1.req_cols = 6'd4;
        if1.req_col_mode = 1'b1; if1.req_scpad_id = 2'd0;
        step;
        if1.req_valid = 1'b0;
        checks++; if (if1.err_pulse !== 1'b1 || if1.beat_valid !== 1'b0) begin errors++;
            $display("FAIL lin_colmode got e=%b v=%b exp e=1 v=0", if1.err_pulse, if1.beat_valid); end
        step;
        checks++; if (if1.req_ready !== 1'b1 || if1.err_pulse !== 1'b0) begin errors++; $display("FAIL lin_recover got rdy=%b exp=1", if1.req_ready); end
        if1.req_valid = 1'b1; if1.req_rows = 6'd2; if1.req_cols = 6'd3; if1.req_col_mode = 1'b0;
        step;
        if1.req_valid = 1'b0;
        step;
        checks++; if (if1.beat_idx !== 5'd1 || if1.beat_enable_mask !== 32'h0000_0007 || if1.beat_shift_mask[2] !== 5'd2 || if1.beat_slot_mask[0] !== 14'd1) begin errors++;
            $display("FAIL lin_beat1 got idx=%0d en=%h sh=%0d slot=%0d exp idx=1 en=7 sh=2 slot=1",
                if1.beat_idx, if1.beat_enable_mask, if1.beat_shift_mask[2], if1.beat_slot_mask[0]); end
        step;
    endtask
    task automatic test_reset_mid;
        req0(14'd200, 6'd8, 6'd32, 1'b0, 2'd0);
        step;
        step;
        checks++; if (if0.beat_idx !== 5'd2 || if0.beat_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got idx=%0d exp=2", if0.beat_idx); end
        rst = 1'b1;
        #1;
        checks++; if (if0.beat_valid !== 1'b0 || if0.req_ready !== 1'b1) begin errors++;
            $display("FAIL mid_async got v=%b rdy=%b exp v=0 rdy=1", if0.beat_valid, if0.req_ready); end
        step;
        rst = 1'b0;
        step;
        req0(14'd300, 6'd2, 6'd32, 1'b0, 2'd0);
        checks++; if (if0.beat_valid !== 1'b1 || if0.beat_idx !== 5'd0 || if0.beat_slot_mask[0] !== 14'd300) begin errors++;
            $display("FAIL mid_restart got v=%b idx=%0d slot=%0d exp v=1 idx=0 slot=300", if0.beat_valid, if0.beat_idx, if0.beat_slot_mask[0]); end
        step;
        step;
        checks++; if (if0.beat_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got v=%b exp=0", if0.beat_valid); end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        {if0.req_valid, if0.req_base_row, if0.req_rows, if0.req_cols, if0.req_col_mode, if0.req_scpad_id} = '0;
        {if1.req_valid, if1.req_base_row, if1.req_rows, if1.req_cols, if1.req_col_mode, if1.req_scpad_id} = '0;
        if0.beat_ready = 1'b1;
        if1.beat_ready = 1'b1;
        step;
        step;
        test_reset;
        rst = 1'b0;
        step;
        test_row_mode;
        step;
        test_col_mode;
        step;
        test_wrap;
        step;
        test_backpressure;
        step;
        test_illegal(6'd0, 6'd4, 2'd0, "rows0");
        test_illegal(6'd4, 6'd33, 2'd0, "cols33");
        test_illegal(6'd4, 6'd4, 2'd2, "scpad2");
        test_linear;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scpad_tile_addr_gen.md
Name: scpad_tile_addr_gen

Overview:
- Multi-cycle tile address sequencer for the scratchpad SRAM controller.
- Accepts one tile request (base slot, rows, cols, orientation, scratchpad id). Emits one beat per SRAM access, each carrying per-bank slot, crossbar shift and lane-enable masks.
- Parametrised successor to the fixed 32-column, 2-scratchpad layout. Generalised in column count, tile size and scratchpad count.
- Adds a diagonal-swizzled layout so row-major and transposed (column) tile reads are both conflict-free, one beat per row or column.

Parameters:
- NUM_COLS, 32: banks per scratchpad, power of 2.
- NUM_ROWS, 16384: slots per bank, power of 2.
- MAX_TILE_SIZE, 32: maximum tile dimension; must be <= NUM_COLS.
- NUM_SCPADS, 2: scratchpad count, >= 2, need not be a power of 2.
- SWIZZLE_EN, 1: 1 = diagonal layout; 0 = linear layout, in which column mode is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  generator can accept a request
- req_base_row  in  ROW_IDX_WIDTH  first slot of the tile
- req_rows  in  MAX_DIM_WIDTH+1  tile rows, legal range 1..MAX_TILE_SIZE
- req_cols  in  MAX_DIM_WIDTH+1  tile cols, legal range 1..MAX_TILE_SIZE
- req_col_mode  in  1  0 = row-major beats, 1 = transposed (column) beats
- req_scpad_id  in  SCPAD_ID_WIDTH  target scratchpad
- beat_valid  out  1  beat valid
- beat_ready  in  1  downstream accepts beat
- beat_slot_mask  out  slot_mask_t  per-bank slot index
- beat_shift_mask  out  shift_mask_t  per-bank destination lane
- beat_enable_mask  out  enable_mask_t  per-bank active
- beat_idx  out  MAX_DIM_WIDTH  beat number within the tile
- beat_last  out  1  final beat of the tile
- beat_scpad_id  out  SCPAD_ID_WIDTH  scratchpad id latched from the request
- err_pulse  out  1  one-cycle illegal-request flag

Behaviour:
- Reset values: state IDLE; req_ready=1; every other output 0.
- States and transitions:
  - IDLE -> RUN on req_valid & req_ready with a legal request.
  - IDLE -> ERR on req_valid & req_ready with an illegal request.
  - ERR -> IDLE after exactly 1 cycle. err_pulse=1 only in ERR; no beats are produced.
  - RUN -> IDLE when the beat with beat_last=1 handshakes.
- req_ready is 1 only in IDLE. There is no back-to-back overlap; there is one idle cycle between tiles.
- Illegal request: rows==0, cols==0, rows>MAX_TILE_SIZE, cols>MAX_TILE_SIZE, scpad_id>=NUM_SCPADS, or (col_mode & SWIZZLE_EN==0).
- Latency: request accepted at cycle N -> first beat_valid at N+1.
- Beat outputs are registered. While beat_valid & !beat_ready, all beat outputs hold stable. The beat counter advances only on handshake.
- Beat count: rows in row mode, cols in column mode. beat_idx counts 0..count-1; beat_last is set when beat_idx==count-1.
- Arithmetic: all slot arithmetic is modulo NUM_ROWS (base near the top wraps to 0). All lane arithmetic is modulo NUM_COLS, i.e. COL_IDX_WIDTH-bit truncation.
- Swizzled placement: element (r,c) lives in bank (c+r) mod NUM_COLS at slot base+r. Linear placement uses bank c.
- Row mode, beat b=r, bank l:
  - c = (l - r) mod N when swizzled, else c = l.
  - enable = (c < cols).
  - slot = base + r.
  - shift = c.
- Column mode, beat b=c, bank l:
  - r = (l - c) mod N.
  - enable = (r < rows).
  - slot = base + r.
  - shift = r.
- Disabled lanes output slot 0 and shift 0.
- Every beat's enabled lanes have distinct shift values (no crossbar conflict).
- The request is latched on acceptance. Changes to req_* during RUN are ignored.
- Reset mid-tile: asynchronous return to IDLE; beat_valid drops immediately; no partial completion is reported.

Decomposition:
- Add to scpad_types_pkg:
  - parameterised widths ROW_IDX_WIDTH, COL_IDX_WIDTH, MAX_DIM_WIDTH, SCPAD_ID_WIDTH;
  - slot_mask_t, shift_mask_t, enable_mask_t;
  - tile_req_t struct (base_row, rows, cols, col_mode, scpad_id);
  - tile_beat_t struct (the masks plus idx, last, id);
  - enum addr_gen_state_t {IDLE, RUN, ERR}.
- One sub-module, scpad_lane_map: purely combinational per-lane mapping. Inputs: beat index, mode, dims, base. Outputs: the three masks. Instantiated once and registered by the parent FSM.

Test Plan:
- Row mode, base=100, rows=4, cols=32, swizzle:
  - exactly 4 beats, first beat_valid 1 cycle after acceptance;
  - beat 1: slot=101 on all lanes; bank 0 shift=31; bank 5 shift=4; enable all 1;
  - beat_last=1 only on beat_idx=3.
- Column mode, base=0, rows=8, cols=3:
  - 3 beats;
  - beat 2: bank 2 slot=0 shift=0; bank 9 slot=7 shift=7;
  - enable = banks 2..9 only; all other lanes slot 0, shift 0.
- Wrap, base=NUM_ROWS-2, rows=4, row mode: slots 16382, 16383, 0, 1 on beats 0..3.
- Backpressure: beat_ready=0 for 5 cycles on beat 0 -> outputs stable; beat_idx stays 0; req_ready stays 0.
- Illegal requests:
  - rows=0 -> err_pulse=1 for 1 cycle, no beat_valid, req_ready returns to 1;
  - col_mode with SWIZZLE_EN=0 -> same response;
  - scpad_id=2 with NUM_SCPADS=2 -> same response.
- Assert rst during beat 2 of an 8-beat tile -> beat_valid=0 and req_ready=1 immediately. A new request afterwards starts at beat_idx 0.
